// File: rtl/multi_watchdog_pkg.sv
// Shared constants, types and address decode for the multi-channel windowed watchdog.
package multi_watchdog_pkg;

    localparam int unsigned ADDR_KEY        = 0;
    localparam int unsigned ADDR_KICK       = 1;
    localparam int unsigned ADDR_CH_BASE    = 2;
    // CTRL and RSTLEN sit directly after the per-channel OPEN/TMO pairs.
    localparam int unsigned ADDR_CTRL_OFS   = 2;
    localparam int unsigned ADDR_RSTLEN_OFS = 3;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_EARLY = 2'b01;
    localparam logic [1:0] CAUSE_TMO   = 2'b10;

    localparam int unsigned RSTLEN_DEFAULT = 16;

    typedef enum logic {
        StLocked,
        StUnlocked
    } lock_state_e;

    typedef enum logic [2:0] {
        RegNone,
        RegKey,
        RegKick,
        RegOpen,
        RegTmo,
        RegCtrl,
        RegRstlen
    } reg_sel_e;

    function automatic int unsigned ctrl_addr(input int unsigned nch);
        return ADDR_CTRL_OFS + 2 * nch;
    endfunction

    function automatic int unsigned rstlen_addr(input int unsigned nch);
        return ADDR_RSTLEN_OFS + 2 * nch;
    endfunction

    function automatic reg_sel_e decode_addr(input int unsigned addr, input int unsigned nch);
        reg_sel_e sel;
        sel = RegNone;
        if (addr == ADDR_KEY) begin
            sel = RegKey;
        end else if (addr == ADDR_KICK) begin
            sel = RegKick;
        end else if (addr < ADDR_CH_BASE + 2 * nch) begin
            sel = addr[0] ? RegTmo : RegOpen;
        end else if (addr == ctrl_addr(nch)) begin
            sel = RegCtrl;
        end else if (addr == rstlen_addr(nch)) begin
            sel = RegRstlen;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wd_channel.sv
// One watchdog channel: free-running window counter with early-kick and timeout detection.
module wd_channel
    import multi_watchdog_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            arm,
    input  logic            kick,
    input  logic [CNTW-1:0] open,
    input  logic [CNTW-1:0] tmo,
    output logic            fault,
    output logic [1:0]      cause
);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;

    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        cause_d = cause_q;
        if (arm) begin
            cnt_d   = '0;
            fault_d = 1'b0;
            cause_d = CAUSE_NONE;
        end else if (!en) begin
            cnt_d = '0;
        end else if (!fault_q) begin
            // A kick on the timeout cycle wins over the timeout.
            if (kick) begin
                if (cnt_q < open) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_EARLY;
                end else begin
                    cnt_d = '0;
                end
            end else if (cnt_q == tmo) begin
                fault_d = 1'b1;
                cause_d = CAUSE_TMO;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign fault = fault_q;
    assign cause = cause_q;

endmodule

// File: rtl/multi_watchdog.sv
// Multi-channel windowed watchdog: key-protected register file, NCH channels and a
// stretched system reset pulse raised on any new channel fault.
module multi_watchdog
    import multi_watchdog_pkg::*;
#(
    parameter int unsigned     NCH  = 4,
    parameter int unsigned     CNTW = 16,
    parameter int unsigned     DW   = 16,
    parameter logic [DW-1:0]   KEY  = DW'(16'hA5C3),
    parameter int unsigned     AW   = $clog2(4 + 2 * NCH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WREN,
    input  logic [AW-1:0]     ABUS,
    input  logic [DW-1:0]     DBUS,
    output logic              RSTOUT,
    output logic              WDFAIL,
    output logic [2*NCH-1:0]  FLSTAT,
    output logic              LOCKERR
);

    lock_state_e     state_q, state_d;
    logic [CNTW-1:0] open_q [NCH];
    logic [CNTW-1:0] open_d [NCH];
    logic [CNTW-1:0] tmo_q  [NCH];
    logic [CNTW-1:0] tmo_d  [NCH];
    logic [NCH-1:0]  en_q, en_d;
    logic [DW-1:0]   rstlen_q, rstlen_d;
    logic            lockerr_q, lockerr_d;
    logic [DW-1:0]   pulse_q, pulse_d;
    logic [NCH-1:0]  fault_prev_q;

    logic [NCH-1:0]  arm;
    logic [NCH-1:0]  kick;
    logic [NCH-1:0]  fault;
    logic [1:0]      cause [NCH];
    reg_sel_e        sel;
    int unsigned     ch_idx;
    logic            rise;

    assign sel    = decode_addr(32'(ABUS), NCH);
    assign ch_idx = (32'(ABUS) - ADDR_CH_BASE) >> 1;

    always_comb begin
        state_d   = state_q;
        open_d    = open_q;
        tmo_d     = tmo_q;
        en_d      = en_q;
        rstlen_d  = rstlen_q;
        lockerr_d = lockerr_q;
        arm       = '0;
        kick      = '0;
        if (WREN) begin
            case (sel)
                RegNone: ;
                RegKey:  state_d = (DBUS == KEY) ? StUnlocked : StLocked;
                RegKick: kick = DBUS[NCH-1:0];
                default: begin
                    if (state_q == StLocked) begin
                        lockerr_d = 1'b1;
                    end else begin
                        // Any protected write, accepted or not, uses up the unlock.
                        state_d = StLocked;
                        case (sel)
                            RegOpen: begin
                                for (int unsigned c = 0; c < NCH; c++) begin
                                    if (ch_idx == c) open_d[c] = DBUS[CNTW-1:0];
                                end
                            end
                            RegTmo: begin
                                if (DBUS[CNTW-1:0] == '0) begin
                                    lockerr_d = 1'b1;
                                end else begin
                                    for (int unsigned c = 0; c < NCH; c++) begin
                                        if (ch_idx == c) tmo_d[c] = DBUS[CNTW-1:0];
                                    end
                                end
                            end
                            RegCtrl: begin
                                en_d = DBUS[NCH-1:0];
                                arm  = DBUS[NCH-1:0];
                            end
                            RegRstlen: rstlen_d = DBUS;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // The pulse length is latched at load time; faults during a pulse are absorbed.
    assign rise = |(fault & ~fault_prev_q);

    always_comb begin
        pulse_d = pulse_q;
        if (pulse_q != '0) begin
            pulse_d = pulse_q - DW'(1);
        end else if (rise) begin
            pulse_d = (rstlen_q == '0) ? DW'(1) : rstlen_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= StLocked;
            open_q       <= '{default: '0};
            tmo_q        <= '{default: '1};
            en_q         <= '0;
            rstlen_q     <= DW'(RSTLEN_DEFAULT);
            lockerr_q    <= 1'b0;
            pulse_q      <= '0;
            fault_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            open_q       <= open_d;
            tmo_q        <= tmo_d;
            en_q         <= en_d;
            rstlen_q     <= rstlen_d;
            lockerr_q    <= lockerr_d;
            pulse_q      <= pulse_d;
            fault_prev_q <= fault;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wd_channel #(
            .CNTW (CNTW)
        ) u_ch (
            .clk   (CLK),
            .rst_n (RST),
            .en    (en_q[c]),
            .arm   (arm[c]),
            .kick  (kick[c]),
            .open  (open_q[c]),
            .tmo   (tmo_q[c]),
            .fault (fault[c]),
            .cause (cause[c])
        );
        assign FLSTAT[2*c+1:2*c] = cause[c];
    end

    assign RSTOUT  = (pulse_q != '0);
    assign WDFAIL  = |fault;
    assign LOCKERR = lockerr_q;

endmodule

// File: tb/tb_multi_watchdog.sv
// Directed self-checking bench for multi_watchdog (NCH=4, CNTW=16, DW=16).
module tb_multi_watchdog;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WREN = 1'b0;
    logic [3:0]  ABUS = '0;
    logic [15:0] DBUS = '0;
    logic        RSTOUT;
    logic        WDFAIL;
    logic [7:0]  FLSTAT;
    logic        LOCKERR;

    int total = 0;
    int bad   = 0;

    multi_watchdog dut (
        .CLK     (CLK),
        .RST     (RST),
        .WREN    (WREN),
        .ABUS    (ABUS),
        .DBUS    (DBUS),
        .RSTOUT  (RSTOUT),
        .WDFAIL  (WDFAIL),
        .FLSTAT  (FLSTAT),
        .LOCKERR (LOCKERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        WREN = 1'b0;
        RST  = 1'b0;
        tick(2);
        RST  = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        ABUS = a;
        DBUS = d;
        WREN = 1'b1;
        tick(1);
        WREN = 1'b0;
    endtask

    task automatic pwr(input logic [3:0] a, input logic [15:0] d);
        wr(4'd0, 16'hA5C3);
        wr(a, d);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (RSTOUT !== 1'b0) begin bad++; $display("FAIL reset_rstout: got %b want 0", RSTOUT); end
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL reset_wdfail: got %b want 0", WDFAIL); end
        total++; if (FLSTAT !== 8'h00) begin bad++; $display("FAIL reset_flstat: got %h want 00", FLSTAT); end
        total++; if (LOCKERR !== 1'b0) begin bad++; $display("FAIL reset_lockerr: got %b want 0", LOCKERR); end
    endtask

    task automatic test_timeout();
        int first_hi = -1;
        int hi_cnt = 0;
        do_reset();
        pwr(4'd3, 16'd10);
        pwr(4'd10, 16'h0001);
        for (int cyc = 1; cyc <= 32; cyc++) begin
            tick(1);
            if (RSTOUT === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = cyc;
            end
            if (cyc == 10) begin
                total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL tmo_early_wdfail: got %b want 0", WDFAIL); end
            end
            if (cyc == 11) begin
                total++; if (WDFAIL !== 1'b1) begin bad++; $display("FAIL tmo_wdfail: got %b want 1", WDFAIL); end
                total++; if (FLSTAT !== 8'b0000_0010) begin bad++; $display("FAIL tmo_flstat: got %b want 00000010", FLSTAT); end
            end
        end
        total++; if (first_hi != 12) begin bad++; $display("FAIL tmo_rstout_start: got %0d want 12", first_hi); end
        total++; if (hi_cnt != 16) begin bad++; $display("FAIL tmo_rstout_len: got %0d want 16", hi_cnt); end
        total++; if (LOCKERR !== 1'b0) begin bad++; $display("FAIL tmo_lockerr: got %b want 0", LOCKERR); end
    endtask

    task automatic test_window();
        do_reset();
        pwr(4'd4, 16'd5);
        pwr(4'd5, 16'd20);
        pwr(4'd10, 16'h0002);
        tick(3);
        wr(4'd1, 16'h0002);
        total++; if (FLSTAT[3:2] !== 2'b01) begin bad++; $display("FAIL win_early_cause: got %b want 01", FLSTAT[3:2]); end
        total++; if (WDFAIL !== 1'b1) begin bad++; $display("FAIL win_early_wdfail: got %b want 1", WDFAIL); end
        pwr(4'd10, 16'h0002);
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL win_rearm: got %b want 0", WDFAIL); end
        tick(5);  wr(4'd1, 16'h0002);
        tick(12); wr(4'd1, 16'h0002);
        tick(20); wr(4'd1, 16'h0002);
        total++; if (FLSTAT !== 8'h00) begin bad++; $display("FAIL win_kicks_ok: got %b want 00000000", FLSTAT); end
        tick(20);
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL win_at_tmo: got %b want 0", WDFAIL); end
        tick(1);
        total++; if (FLSTAT[3:2] !== 2'b10) begin bad++; $display("FAIL win_tmo_cause: got %b want 10", FLSTAT[3:2]); end
    endtask

    task automatic test_lock();
        do_reset();
        wr(4'd9, 16'd3);
        total++; if (LOCKERR !== 1'b1) begin bad++; $display("FAIL lock_locked_err: got %b want 1", LOCKERR); end
        pwr(4'd10, 16'h0004);
        tick(12);
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL lock_tmo_ignored: got %b want 0", WDFAIL); end

        do_reset();
        wr(4'd0, 16'h1234);
        wr(4'd9, 16'd3);
        total++; if (LOCKERR !== 1'b1) begin bad++; $display("FAIL lock_wrongkey_err: got %b want 1", LOCKERR); end
        pwr(4'd10, 16'h0004);
        tick(12);
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL lock_wrongkey_ignored: got %b want 0", WDFAIL); end

        do_reset();
        pwr(4'd3, 16'd0);
        total++; if (LOCKERR !== 1'b1) begin bad++; $display("FAIL lock_tmo0_err: got %b want 1", LOCKERR); end
        wr(4'd5, 16'd3);
        pwr(4'd10, 16'h0003);
        tick(10);
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL lock_tmo0_consumed: got %b want 0", WDFAIL); end
    endtask

    task automatic test_kick_unlock();
        do_reset();
        wr(4'd0, 16'hA5C3);
        wr(4'd1, 16'h0000);
        wr(4'd4, 16'd8);
        total++; if (LOCKERR !== 1'b0) begin bad++; $display("FAIL ku_open_accepted: got %b want 0", LOCKERR); end
        wr(4'd4, 16'd2);
        total++; if (LOCKERR !== 1'b1) begin bad++; $display("FAIL ku_second_rejected: got %b want 1", LOCKERR); end
        pwr(4'd10, 16'h0002);
        tick(6);
        wr(4'd1, 16'h0002);
        total++; if (FLSTAT[3:2] !== 2'b01) begin bad++; $display("FAIL ku_open_value: got %b want 01", FLSTAT[3:2]); end
    endtask

    task automatic test_back_to_back();
        int first_hi = -1;
        int hi_cnt = 0;
        do_reset();
        pwr(4'd11, 16'd4);
        pwr(4'd3, 16'd5);
        pwr(4'd5, 16'd7);
        pwr(4'd9, 16'd5);
        pwr(4'd10, 16'h000B);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick(1);
            if (RSTOUT === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = cyc;
            end
            if (cyc == 5) begin
                total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL b2b_pre: got %b want 0", WDFAIL); end
            end
            if (cyc == 6) begin
                total++; if (FLSTAT !== 8'b10_00_00_10) begin bad++; $display("FAIL b2b_flstat: got %b want 10000010", FLSTAT); end
            end
            if (cyc == 8) begin
                total++; if (FLSTAT !== 8'b10_00_10_10) begin bad++; $display("FAIL b2b_ch1: got %b want 10001010", FLSTAT); end
            end
        end
        total++; if (first_hi != 7) begin bad++; $display("FAIL b2b_start: got %0d want 7", first_hi); end
        total++; if (hi_cnt != 4) begin bad++; $display("FAIL b2b_len: got %0d want 4", hi_cnt); end
    endtask

    task automatic test_rst_mid_pulse();
        do_reset();
        pwr(4'd3, 16'd10);
        pwr(4'd10, 16'h0001);
        tick(14);
        total++; if (RSTOUT !== 1'b1) begin bad++; $display("FAIL rmp_pulse: got %b want 1", RSTOUT); end
        RST = 1'b0;
        tick(1);
        total++; if (RSTOUT !== 1'b0) begin bad++; $display("FAIL rmp_rstout: got %b want 0", RSTOUT); end
        total++; if (FLSTAT !== 8'h00) begin bad++; $display("FAIL rmp_flstat: got %b want 00000000", FLSTAT); end
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL rmp_wdfail: got %b want 0", WDFAIL); end
        RST = 1'b1;
        tick(12);
        total++; if (WDFAIL !== 1'b0) begin bad++; $display("FAIL rmp_en_cleared: got %b want 0", WDFAIL); end
        wr(4'd3, 16'd4);
        total++; if (LOCKERR !== 1'b1) begin bad++; $display("FAIL rmp_lock_closed: got %b want 1", LOCKERR); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_window();
        test_lock();
        test_kick_unlock();
        test_back_to_back();
        test_rst_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
